// File: rtl/vga_frame_reader.sv
// -----------------------------------------------------------------------------
// vga_frame_reader
//
// Read-side master for the 12-bit graphics frame memory. Generates VGA raster
// timing (640x480@60 Hz by default) from the system clock and streams the
// frame linearly out of the memory's synchronous read port. The memory read
// latency is absorbed inside the pixel period, so each returned pixel is
// registered together with its hsync/vsync/video_on.
//
// Ports
//   clk          system clock (single domain)
//   reset        asynchronous, active-high; clears all state
//   ram_data     pixel returned by the frame memory (RD_LAT clk after ram_addr)
//   ram_addr     linear read address of the current raster position
//   ram_en       read enable, high during phases 0..RD_LAT of visible pixels
//   hsync        horizontal sync, active low
//   vsync        vertical sync, active low
//   video_on     output pixel lies in the visible area
//   rgb          pixel to the DAC; forced to 0 outside the visible area
//   frame_start  one-clk pulse when pixel (0,0) is presented
// -----------------------------------------------------------------------------
module vga_frame_reader #(
    parameter int CLK_DIV   = 4,
    parameter int RD_LAT    = 2,
    parameter int RAM_WIDTH = 12,
    parameter int ADDR_W    = 19,
    parameter int H_VIS     = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VIS     = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RAM_WIDTH-1:0] ram_data,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic                 ram_en,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 video_on,
    output logic [RAM_WIDTH-1:0] rgb,
    output logic                 frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int PW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] PH_RD   = PW'(RD_LAT);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_VISL = HW'(H_VIS);
    localparam logic [HW-1:0] HS_ON  = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_OFF = HW'(H_VIS + H_FP + H_SYNC);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_VISL = VW'(V_VIS);
    localparam logic [VW-1:0] VS_ON  = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_OFF = VW'(V_VIS + V_FP + V_SYNC);

    logic [PW-1:0]        ph_q, ph_d;
    logic [HW-1:0]        h_q, h_d;
    logic [VW-1:0]        v_q, v_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic                 hsync_q, hsync_d;
    logic                 vsync_q, vsync_d;
    logic                 von_q, von_d;
    logic [RAM_WIDTH-1:0] rgb_q, rgb_d;
    logic                 fs_q, fs_d;

    logic                 tick, load, visible, nxt_vis;
    logic [HW-1:0]        h_nxt;
    logic [VW-1:0]        v_nxt;

    always_comb begin
        tick    = (ph_q == PH_LAST);
        load    = (ph_q == PH_RD);
        visible = (h_q < H_VISL) && (v_q < V_VISL);

        // Raster position that follows the current one.
        h_nxt = (h_q == H_LAST) ? '0 : h_q + HW'(1);
        v_nxt = v_q;
        if (h_q == H_LAST) begin
            v_nxt = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end
        nxt_vis = (h_nxt < H_VISL) && (v_nxt < V_VISL);

        ph_d   = tick ? '0 : ph_q + PW'(1);
        h_d    = tick ? h_nxt : h_q;
        v_d    = tick ? v_nxt : v_q;

        // Incremental linear address: blanking simply holds, so (last,y) and
        // (0,y+1) come out as consecutive addresses without a multiplier.
        addr_d = addr_q;
        if (tick) begin
            if (h_nxt == '0 && v_nxt == '0) begin
                addr_d = '0;
            end else if (nxt_vis) begin
                addr_d = addr_q + ADDR_W'(1);
            end
        end

        // Output stage loads once per pixel, on the edge where the memory
        // data for the current address is valid.
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        von_d   = von_q;
        rgb_d   = rgb_q;
        fs_d    = 1'b0;
        if (load) begin
            hsync_d = !((h_q >= HS_ON) && (h_q < HS_OFF));
            vsync_d = !((v_q >= VS_ON) && (v_q < VS_OFF));
            von_d   = visible;
            rgb_d   = visible ? ram_data : '0;
            fs_d    = (h_q == '0) && (v_q == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ph_q    <= '0;
            h_q     <= '0;
            v_q     <= '0;
            addr_q  <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            von_q   <= 1'b0;
            rgb_q   <= '0;
            fs_q    <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            h_q     <= h_d;
            v_q     <= v_d;
            addr_q  <= addr_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            von_q   <= von_d;
            rgb_q   <= rgb_d;
            fs_q    <= fs_d;
        end
    end

    // Combinational so the read of pixel (0,0) starts in the very first cycle
    // after release; reset gates it because (0,0) is itself visible.
    assign ram_en      = !reset && visible && (ph_q <= PH_RD);
    assign ram_addr    = addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = von_q;
    assign rgb         = rgb_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_frame_reader.sv
module tb_vga_frame_reader;

    typedef struct packed {
        logic        en;
        logic [18:0] addr;
        logic        hs;
        logic        vs;
        logic        von;
        logic        fs;
        logic [11:0] rgb;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A: default timing, CLK_DIV=4 ----------------
    logic        rst_a = 1'b1;
    logic [11:0] rd_a;
    logic [18:0] addr_a;
    logic        en_a, hs_a, vs_a, von_a, fs_a;
    logic [11:0] rgb_a;
    logic [11:0] s1a, s2a;

    vga_frame_reader dut_a (
        .clk(clk), .reset(rst_a), .ram_data(rd_a), .ram_addr(addr_a),
        .ram_en(en_a), .hsync(hs_a), .vsync(vs_a), .video_on(von_a),
        .rgb(rgb_a), .frame_start(fs_a)
    );

    // Memory with 2-clk read latency, mem[a] = a[11:0].
    always @(posedge clk) begin
        if (en_a) s1a <= addr_a[11:0];
        s2a <= s1a;
    end
    assign rd_a = s2a;

    // ---------------- instance B: CLK_DIV=3, 6-line frame ----------------
    logic        rst_b = 1'b1;
    logic        fff_b = 1'b0;
    logic [11:0] rd_b;
    logic [18:0] addr_b;
    logic        en_b, hs_b, vs_b, von_b, fs_b;
    logic [11:0] rgb_b;
    logic [11:0] s1b, s2b;

    vga_frame_reader #(.CLK_DIV(3), .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut_b (
        .clk(clk), .reset(rst_b), .ram_data(rd_b), .ram_addr(addr_b),
        .ram_en(en_b), .hsync(hs_b), .vsync(vs_b), .video_on(von_b),
        .rgb(rgb_b), .frame_start(fs_b)
    );

    always @(posedge clk) begin
        if (en_b) s1b <= addr_b[11:0];
        s2b <= s1b;
    end
    assign rd_b = fff_b ? 12'hFFF : s2b;

    // Closed-form expectation from t = clock edges since reset release,
    // 800-pixel lines. Pixel k is presented after edge 3 + div*k.
    function automatic exp_t model(input int t, input int div, input int vvis,
                                   input int vfp, input int vsy, input int vtot,
                                   input bit fff);
        exp_t e;
        int   p, ph, h, v, k, hk, vk;
        bit   vis;
        p  = t / div;
        ph = t % div;
        h  = p % 800;
        v  = (p / 800) % vtot;
        vis = (h < 640) && (v < vvis);
        e.en = vis && (ph <= 2);
        if (vis)           e.addr = 19'(v * 640 + h);
        else if (v < vvis) e.addr = 19'(v * 640 + 639);
        else               e.addr = 19'(vvis * 640 - 1);
        if (t < 3) begin
            e.hs = 1'b1; e.vs = 1'b1; e.von = 1'b0; e.fs = 1'b0; e.rgb = 12'h0;
        end else begin
            k  = (t - 3) / div;
            hk = k % 800;
            vk = (k / 800) % vtot;
            vis   = (hk < 640) && (vk < vvis);
            e.von = vis;
            e.rgb = vis ? (fff ? 12'hFFF : 12'((vk * 640 + hk) % 4096)) : 12'h0;
            e.hs  = !(hk >= 656 && hk < 752);
            e.vs  = !(vk >= vvis + vfp && vk < vvis + vfp + vsy);
            e.fs  = ((t - 3) % div == 0) && hk == 0 && vk == 0;
        end
        return e;
    endfunction

    // ---------------- monitor A ----------------
    int   ta = 0, bad_a = 0, von_rise_a = -1, nhf_a = 0, hsr_a = -1;
    int   hfa[0:1];
    bit   hs_prev_a = 1'b1, von_prev_a = 1'b0;
    exp_t ea;

    always @(posedge clk) begin
        #1;
        if (rst_a) begin
            ta = 0; bad_a = 0; von_rise_a = -1; nhf_a = 0; hsr_a = -1;
            hs_prev_a = 1'b1; von_prev_a = 1'b0;
        end else begin
            ta++;
            ea = model(ta, 4, 480, 10, 2, 525, 1'b0);
            if ({en_a, addr_a, hs_a, vs_a, von_a, fs_a, rgb_a} !== ea) bad_a++;
            if (!von_prev_a && von_a && von_rise_a < 0) von_rise_a = ta;
            if (hs_prev_a && !hs_a && nhf_a < 2) begin hfa[nhf_a] = ta; nhf_a++; end
            if (!hs_prev_a && hs_a && nhf_a == 1 && hsr_a < 0) hsr_a = ta;
            hs_prev_a  = hs_a;
            von_prev_a = von_a;
        end
    end

    // ---------------- monitor B ----------------
    int   tb_t = 0, bad_b = 0, max_b = 0, vis_b = 0, nfs_b = 0, nhf_b = 0;
    int   hsr_b = -1, vsl_b = 0, blank_b = 0;
    int   fsb[0:1];
    int   hfb[0:1];
    bit   hs_prev_b = 1'b1;
    exp_t eb;

    always @(posedge clk) begin
        #1;
        if (rst_b) begin
            tb_t = 0; bad_b = 0; max_b = 0; vis_b = 0; nfs_b = 0; nhf_b = 0;
            hsr_b = -1; vsl_b = 0; blank_b = 0; hs_prev_b = 1'b1;
        end else begin
            tb_t++;
            eb = model(tb_t, 3, 3, 1, 1, 6, fff_b);
            if ({en_b, addr_b, hs_b, vs_b, von_b, fs_b, rgb_b} !== eb) bad_b++;
            if (int'(addr_b) > max_b) max_b = int'(addr_b);
            if (tb_t >= 3 && (tb_t - 3) % 3 == 0 && (tb_t - 3) / 3 < 4800 && von_b) vis_b++;
            if (fs_b && nfs_b < 2) begin fsb[nfs_b] = tb_t; nfs_b++; end
            if (hs_prev_b && !hs_b && nhf_b < 2) begin hfb[nhf_b] = tb_t; nhf_b++; end
            if (!hs_prev_b && hs_b && nhf_b == 1 && hsr_b < 0) hsr_b = tb_t;
            hs_prev_b = hs_b;
            if (!vs_b && tb_t <= 14403) vsl_b++;
            if (fff_b && (von_b ? (rgb_b !== 12'hFFF) : (rgb_b !== 12'h000))) blank_b++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_t(input bit sel_b, input int target, input string tag);
        int n = 0;
        while ((sel_b ? tb_t : ta) != target && n < 40000) begin
            @(posedge clk); #2;
            n++;
        end
        chk(tag, sel_b ? tb_t : ta, target);
    endtask

    task automatic wait_fs_a(input string tag);
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (!fs_a && n < 12);
        chk(tag, n, 3);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_hsync", hs_a, 1);
        chk("rst_vsync", vs_a, 1);
        chk("rst_video_on", von_a, 0);
        chk("rst_rgb", rgb_a, 0);
        chk("rst_frame_start", fs_a, 0);
        chk("rst_ram_en", en_a, 0);
        chk("rst_ram_addr", addr_a, 0);

        // Free run: first pixel, (5,0), (0,1)
        @(negedge clk) rst_a = 1'b0;
        wait_fs_a("first_load_latency");
        chk("first_rgb", rgb_a, 12'h000);
        chk("first_video_on", von_a, 1);
        @(posedge clk); #2;
        chk("fs_pulse_clear", fs_a, 0);
        wait_t(1'b0, 23, "reach_px5");
        chk("px5_rgb", rgb_a, 12'h005);
        wait_t(1'b0, 3203, "reach_px_0_1");
        chk("px_0_1_rgb", rgb_a, 12'h280);
        chk("px_0_1_video_on", von_a, 1);

        // Horizontal sync timing
        wait_t(1'b0, 6000, "reach_line2");
        chk("hsync_offset", hfa[0] - von_rise_a, 656 * 4);
        chk("hsync_low_len", hsr_a - hfa[0], 384);
        chk("line_period_div4", hfa[1] - hfa[0], 3200);

        // Mid-frame reset at (300,2)
        wait_t(1'b0, 7603, "reach_px_300_2");
        chk("px_300_2_rgb", rgb_a, 12'h62C);
        chk("a_cycle_model", bad_a, 0);
        #1 rst_a = 1'b1;
        #1;
        chk("async_hsync", hs_a, 1);
        chk("async_vsync", vs_a, 1);
        chk("async_video_on", von_a, 0);
        chk("async_rgb", rgb_a, 0);
        chk("async_frame_start", fs_a, 0);
        chk("async_ram_en", en_a, 0);
        chk("async_ram_addr", addr_a, 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_a = 1'b0;
        wait_fs_a("restart_latency");
        chk("restart_rgb", rgb_a, 12'h000);
        chk("restart_video_on", von_a, 1);
        wait_t(1'b0, 400, "reach_restart_400");
        chk("a_cycle_model_restart", bad_a, 0);

        // Instance B, normal memory: full frame
        @(negedge clk) rst_b = 1'b0;
        wait_t(1'b1, 14410, "b_frame1");
        chk("b_cycle_model", bad_b, 0);
        chk("b_addr_max", max_b, 1919);
        chk("b_visible_count", vis_b, 1920);
        chk("b_frame_period", fsb[1] - fsb[0], 14400);
        chk("b_line_period_div3", hfb[1] - hfb[0], 2400);
        chk("b_hsync_low_len", hsr_b - hfb[0], 288);
        chk("b_vsync_low_len", vsl_b, 2400);

        // Instance B, ram_data stuck at 0xFFF: blanking must still force 0
        @(negedge clk) rst_b = 1'b1;
        fff_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        wait_t(1'b1, 14410, "b_frame2");
        chk("b_fff_cycle_model", bad_b, 0);
        chk("b_fff_blanking", blank_b, 0);
        chk("b_fff_visible_count", vis_b, 1920);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
